// File: rtl/vga_scan_generator.sv
// Purpose : parametrised VGA scan timing and cell-scaled video-RAM read address generator.
// Latency : address 1 pixel tick after the (h,v) count; RGB/syncs/vblank 2 ticks after it.
// Backpressure: none; free-running while iEnable is high. iEnable low blanks the outputs and holds the counters at 0.
//
// Ports:
//   Clock, Reset (async active-low), iEnable (scan enable), iMemData (RAM read data)
//   oReadAddress {column,row}, oVGA_RGB, oHsync, oVsync, oFrameStart, oVBlank,
//   oHcounter/oVcounter (stage-0 counters)
module vga_scan_generator #(
    parameter int CLK_DIV         = 2,
    parameter int H_DISP          = 640,
    parameter int H_FP            = 16,
    parameter int H_PW            = 96,
    parameter int H_BP            = 48,
    parameter int V_DISP          = 480,
    parameter int V_FP            = 10,
    parameter int V_PW            = 2,
    parameter int V_BP            = 29,
    parameter int CNT_W           = 10,
    parameter int CELL_X_LOG2     = 3,
    parameter int CELL_Y_LOG2     = 4,
    parameter int COL_W           = 7,
    parameter int ROW_W           = 6,
    parameter int RGB_W           = 3,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     iEnable,
    input  logic [RGB_W-1:0]         iMemData,
    output logic [COL_W+ROW_W-1:0]   oReadAddress,
    output logic [RGB_W-1:0]         oVGA_RGB,
    output logic                     oHsync,
    output logic                     oVsync,
    output logic                     oFrameStart,
    output logic                     oVBlank,
    output logic [CNT_W-1:0]         oHcounter,
    output logic [CNT_W-1:0]         oVcounter
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int ADR_W = COL_W + ROW_W;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_DISP_C   = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_DISP + H_FP);
    localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_DISP + H_FP + H_PW);
    localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_DISP + H_FP + H_PW + H_BP - 1);
    localparam logic [CNT_W-1:0] V_DISP_C   = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_DISP + V_FP);
    localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_DISP + V_FP + V_PW);
    localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_DISP + V_FP + V_PW + V_BP - 1);

    // Output level of an inactive sync pin.
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    // Divider and stage 0
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    // Stage 1
    logic             active_q, active_d;
    logic [ADR_W-1:0] addr_q, addr_d;
    logic             hs_q, hs_d, vs_q, vs_d;
    logic             first_q, first_d;
    logic             vb_q, vb_d;
    // Stage 2
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             vblank_q, vblank_d;
    logic             fs_q, fs_d;

    logic tick;
    logic h_wrap;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    assign tick   = (div_q == DIV_LAST);
    assign h_wrap = (h_q == H_LAST_C);
    // The cast both drops the sub-cell bits and zero-fills when the counter is narrower than the field.
    assign col    = COL_W'(h_q >> CELL_X_LOG2);
    assign row    = ROW_W'(v_q >> CELL_Y_LOG2);

    always_comb begin
        div_d    = div_q;
        h_d      = h_q;
        v_d      = v_q;
        active_d = active_q;
        addr_d   = addr_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        first_d  = first_q;
        vb_d     = vb_q;
        rgb_d    = rgb_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        vblank_d = vblank_q;
        // Frame-start is a single-clock pulse even when ticks are several clocks apart.
        fs_d     = 1'b0;

        if (!iEnable) begin
            div_d    = '0;
            h_d      = '0;
            v_d      = '0;
            active_d = 1'b0;
            addr_d   = '0;
            hs_d     = 1'b0;
            vs_d     = 1'b0;
            first_d  = 1'b0;
            vb_d     = 1'b0;
            rgb_d    = '0;
            hsync_d  = SYNC_IDLE;
            vsync_d  = SYNC_IDLE;
            vblank_d = 1'b0;
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                // Stage 0: scan counters
                if (h_wrap) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST_C) ? '0 : v_q + 1'b1;
                end else begin
                    h_d = h_q + 1'b1;
                end

                // Stage 1: decode the current count
                active_d = (h_q < H_DISP_C) && (v_q < V_DISP_C);
                addr_d   = active_d ? {col, row} : '0;
                hs_d     = (h_q >= HS_START_C) && (h_q < HS_END_C);
                vs_d     = (v_q >= VS_START_C) && (v_q < VS_END_C);
                first_d  = (h_q == '0) && (v_q == '0);
                vb_d     = (v_q >= V_DISP_C);

                // Stage 2: RAM data for the stage-1 address lines up with the delayed flags
                rgb_d    = active_q ? iMemData : '0;
                hsync_d  = hs_q ^ SYNC_IDLE;
                vsync_d  = vs_q ^ SYNC_IDLE;
                vblank_d = vb_q;
                fs_d     = first_q;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            active_q <= 1'b0;
            addr_q   <= '0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            first_q  <= 1'b0;
            vb_q     <= 1'b0;
            rgb_q    <= '0;
            hsync_q  <= SYNC_IDLE;
            vsync_q  <= SYNC_IDLE;
            vblank_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            active_q <= active_d;
            addr_q   <= addr_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            first_q  <= first_d;
            vb_q     <= vb_d;
            rgb_q    <= rgb_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            vblank_q <= vblank_d;
            fs_q     <= fs_d;
        end
    end

    assign oReadAddress = addr_q;
    assign oVGA_RGB     = rgb_q;
    assign oHsync       = hsync_q;
    assign oVsync       = vsync_q;
    assign oFrameStart  = fs_q;
    assign oVBlank      = vblank_q;
    assign oHcounter    = h_q;
    assign oVcounter    = v_q;

endmodule

// File: tb/tb_vga_scan_generator.sv
module tb_vga_scan_generator;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic iEnable = 1'b1;
    int   cyc = 0;
    int   rel = 0;
    int   checks = 0;
    int   passed = 0;
    int   fails = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // A: defaults, B: tiny timing with CLK_DIV=1, C: defaults with active-high syncs
    logic [12:0] addr_a, addr_b, addr_c;
    logic [2:0]  rgb_a, rgb_b, rgb_c, mem_a, mem_b, mem_c;
    logic        hs_a, hs_b, hs_c, vs_a, vs_b, vs_c;
    logic        fs_a, fs_b, fs_c, vb_a, vb_b, vb_c;
    logic [9:0]  hc_a, hc_b, hc_c, vc_a, vc_b, vc_c;

    // Memory model: returns the low three address bits, combinationally.
    assign mem_a = addr_a[2:0];
    assign mem_b = addr_b[2:0];
    assign mem_c = addr_c[2:0];

    vga_scan_generator dut_a (
        .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iMemData(mem_a),
        .oReadAddress(addr_a), .oVGA_RGB(rgb_a), .oHsync(hs_a), .oVsync(vs_a),
        .oFrameStart(fs_a), .oVBlank(vb_a), .oHcounter(hc_a), .oVcounter(vc_a));

    vga_scan_generator #(
        .CLK_DIV(1), .H_DISP(4), .H_FP(1), .H_PW(1), .H_BP(1),
        .V_DISP(2), .V_FP(1), .V_PW(1), .V_BP(1),
        .CELL_X_LOG2(0), .CELL_Y_LOG2(0)
    ) dut_b (
        .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iMemData(mem_b),
        .oReadAddress(addr_b), .oVGA_RGB(rgb_b), .oHsync(hs_b), .oVsync(vs_b),
        .oFrameStart(fs_b), .oVBlank(vb_b), .oHcounter(hc_b), .oVcounter(vc_b));

    vga_scan_generator #(.SYNC_ACTIVE_LOW(0)) dut_c (
        .Clock(Clock), .Reset(Reset), .iEnable(iEnable), .iMemData(mem_c),
        .oReadAddress(addr_c), .oVGA_RGB(rgb_c), .oHsync(hs_c), .oVsync(vs_c),
        .oFrameStart(fs_c), .oVBlank(vb_c), .oHcounter(hc_c), .oVcounter(vc_c));

    typedef struct packed {
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic       vb;
        logic       fs;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected stage-2 outputs of B right after clock edge k counted from restart.
    function automatic exp_t exp_b(input int k);
        exp_t e;
        int n, h, v;
        e = '{rgb: 3'd0, hs: 1'b1, vs: 1'b1, vb: 1'b0, fs: 1'b0};
        if (k >= 2) begin
            n = k - 2;
            h = n % 7;
            v = (n / 7) % 5;
            e.rgb = (h < 4 && v < 2) ? 3'(v) : 3'd0;
            e.hs  = (h != 5);
            e.vs  = (v != 3);
            e.vb  = (v >= 2);
            e.fs  = (n % 35 == 0);
        end
        return e;
    endfunction

    // Expected read address of B right after clock edge k (k >= 1).
    function automatic logic [31:0] exp_addr_b(input int k);
        int n, h, v;
        n = k - 1;
        h = n % 7;
        v = (n / 7) % 5;
        return (h < 4 && v < 2) ? 32'((h << 6) | v) : 32'd0;
    endfunction

    // Runs n clocks after a restart (reset release or enable rise made on the previous negedge),
    // scoreboarding B and timing the first frame-start of A and C.
    task automatic run_sb(input int n);
        exp_t e;
        int fa_first, fa_cnt, fc_first;
        fa_first = -1; fa_cnt = 0; fc_first = -1;
        sb_q.delete();
        sb_q.push_back(exp_b(1));
        sb_q.push_back(exp_b(2));
        for (int k = 1; k <= n; k++) begin
            @(negedge Clock);
            e = sb_q.pop_front();
            chk("b_rgb",   32'(rgb_b), 32'(e.rgb));
            chk("b_hsync", 32'(hs_b),  32'(e.hs));
            chk("b_vsync", 32'(vs_b),  32'(e.vs));
            chk("b_vblank",32'(vb_b),  32'(e.vb));
            chk("b_fstart",32'(fs_b),  32'(e.fs));
            chk("b_addr",  32'(addr_b), exp_addr_b(k));
            chk("b_hcnt",  32'(hc_b),  32'(k % 7));
            chk("b_vcnt",  32'(vc_b),  32'((k / 7) % 5));
            sb_q.push_back(exp_b(k + 2));
            if (fs_a) begin
                fa_cnt++;
                if (fa_first < 0) fa_first = k;
            end
            if (fs_c && fc_first < 0) fc_first = k;
        end
        chk("a_fstart_first", 32'(fa_first), 32'd4);
        chk("a_fstart_count", 32'(fa_cnt), 32'd1);
        chk("c_fstart_first", 32'(fc_first), 32'd4);
    endtask

    // Releases reset, checks the first frame, then measures two lines of hsync on A and C.
    task automatic startup;
        int a_low, c_high, a_vlow, c_vhigh, fall1, fall2, k;
        logic prev;
        @(negedge Clock);
        Reset = 1'b1;
        rel = cyc;
        run_sb(70);
        a_low = 0; c_high = 0; a_vlow = 0; c_vhigh = 0; fall1 = -1; fall2 = -1;
        prev = hs_a;
        for (int i = 0; i < 3200; i++) begin
            @(negedge Clock);
            k = cyc - rel;
            if (!hs_a) a_low++;
            if (hs_c)  c_high++;
            if (!vs_a) a_vlow++;
            if (vs_c)  c_vhigh++;
            if (prev && !hs_a) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            prev = hs_a;
        end
        chk("a_hsync_low_clocks",  32'(a_low),  32'd384);
        chk("c_hsync_high_clocks", 32'(c_high), 32'd384);
        chk("a_vsync_idle",        32'(a_vlow), 32'd0);
        chk("c_vsync_idle",        32'(c_vhigh),32'd0);
        chk("a_hsync_first_fall",  32'(fall1),  32'd1316);
        chk("a_hsync_period",      32'(fall2 - fall1), 32'd1600);
    endtask

    initial begin
        int waited;

        // Reset values
        repeat (3) @(negedge Clock);
        chk("rst_a_rgb",    32'(rgb_a),  32'd0);
        chk("rst_a_addr",   32'(addr_a), 32'd0);
        chk("rst_a_hsync",  32'(hs_a),   32'd1);
        chk("rst_a_vsync",  32'(vs_a),   32'd1);
        chk("rst_a_fstart", 32'(fs_a),   32'd0);
        chk("rst_a_vblank", 32'(vb_a),   32'd0);
        chk("rst_a_hcnt",   32'(hc_a),   32'd0);
        chk("rst_a_vcnt",   32'(vc_a),   32'd0);
        chk("rst_c_hsync",  32'(hs_c),   32'd0);
        chk("rst_c_vsync",  32'(vs_c),   32'd0);

        startup();

        // Pixel (8,16): address one tick later, colour two ticks later
        while (cyc - rel < 25618) @(negedge Clock);
        chk("a_addr_8_16", 32'(addr_a), 32'h041);
        chk("a_hcnt_9",    32'(hc_a),   32'd9);
        chk("a_vcnt_16",   32'(vc_a),   32'd16);
        while (cyc - rel < 25620) @(negedge Clock);
        chk("a_rgb_8_16",  32'(rgb_a),  32'd1);

        // Pixel (700,16) lies in the horizontal sync region
        while (cyc - rel < 27002) @(negedge Clock);
        chk("a_addr_blank", 32'(addr_a), 32'd0);
        while (cyc - rel < 27004) @(negedge Clock);
        chk("a_rgb_blank",   32'(rgb_a), 32'd0);
        chk("a_hsync_in_pw", 32'(hs_a),  32'd0);
        chk("c_hsync_in_pw", 32'(hs_c),  32'd1);
        chk("a_vblank_line16", 32'(vb_a), 32'd0);

        // Asynchronous reset in the middle of hsync, checked before any clock edge
        #2 Reset = 1'b0;
        #1;
        chk("arst_a_hsync", 32'(hs_a),  32'd1);
        chk("arst_c_hsync", 32'(hs_c),  32'd0);
        chk("arst_a_hcnt",  32'(hc_a),  32'd0);
        chk("arst_a_vcnt",  32'(vc_a),  32'd0);
        chk("arst_a_rgb",   32'(rgb_a), 32'd0);

        startup();

        // Drop enable while B is in vertical sync
        waited = 0;
        while (vs_b !== 1'b0 && waited < 40) begin
            @(negedge Clock);
            waited++;
        end
        chk("b_vsync_reached", 32'(vs_b), 32'd0);
        iEnable = 1'b0;
        @(negedge Clock);
        chk("en_b_hcnt",   32'(hc_b),   32'd0);
        chk("en_b_vcnt",   32'(vc_b),   32'd0);
        chk("en_b_hsync",  32'(hs_b),   32'd1);
        chk("en_b_vsync",  32'(vs_b),   32'd1);
        chk("en_b_rgb",    32'(rgb_b),  32'd0);
        chk("en_b_addr",   32'(addr_b), 32'd0);
        chk("en_b_vblank", 32'(vb_b),   32'd0);
        chk("en_a_hcnt",   32'(hc_a),   32'd0);
        chk("en_a_hsync",  32'(hs_a),   32'd1);
        chk("en_c_hsync",  32'(hs_c),   32'd0);
        repeat (9) @(negedge Clock);
        chk("en_hold_a_hcnt", 32'(hc_a), 32'd0);
        chk("en_hold_b_vcnt", 32'(vc_b), 32'd0);
        chk("en_hold_b_vsync",32'(vs_b), 32'd1);
        iEnable = 1'b1;
        run_sb(70);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
